// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : cpu_control_unit
// Brief   : Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Rev     : 1.0  initial release
// ============================================================================
module cpu_control_unit #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_en,
    input  logic [WIDTH-1:0] imem_data,
    output logic [2:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zf,
    output logic             vf,
    output logic [WIDTH-1:0] pc,
    output logic             halted
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_OPND     = 3'd3,
        S_OUT_WAIT = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    localparam logic [2:0] c_OP_ADD  = 3'd0;
    localparam logic [2:0] c_OP_AND  = 3'd1;
    localparam logic [2:0] c_OP_NOT  = 3'd2;
    localparam logic [2:0] c_OP_LDI  = 3'd3;
    localparam logic [2:0] c_OP_JZ   = 3'd4;
    localparam logic [2:0] c_OP_OUT  = 3'd5;
    localparam logic [2:0] c_OP_NOP  = 3'd6;
    localparam logic [2:0] c_OP_HALT = 3'd7;

    state_t           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] rf_q [NREGS];
    logic             zf_q;
    logic             vf_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             halted_q;

    logic [2:0] w_op;
    logic [1:0] w_rd;
    logic [1:0] w_rs;
    logic       w_alu_exec;
    logic       w_opnd_fetch;
    logic       w_unused_ir0;

    assign w_op         = ir_q[7:5];
    assign w_rd         = ir_q[4:3];
    assign w_rs         = ir_q[2:1];
    assign w_unused_ir0 = ir_q[0];

    // ADD/AND/NOT share the low opcode values, so "op <= NOT" selects ALU ops.
    assign w_alu_exec   = (state_q == S_EXEC) && (w_op <= c_OP_NOT);
    assign w_opnd_fetch = (state_q == S_EXEC) && ((w_op == c_OP_LDI) || (w_op == c_OP_JZ));

    assign imem_en    = (state_q == S_FETCH) || w_opnd_fetch;
    assign imem_addr  = pc_q;
    assign alu_opcode = w_alu_exec ? w_op : 3'b000;
    assign alu_a      = w_alu_exec ? rf_q[w_rd] : '0;
    assign alu_b      = w_alu_exec ? rf_q[w_rs] : '0;

    assign pc        = pc_q;
    assign zf        = zf_q;
    assign vf        = vf_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign halted    = halted_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            zf_q        <= 1'b0;
            vf_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            halted_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    ir_q    <= imem_data;
                    pc_q    <= pc_q + 1'b1;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    case (w_op)
                        c_OP_ADD, c_OP_AND, c_OP_NOT: begin
                            rf_q[w_rd] <= alu_res;
                            zf_q       <= alu_zero;
                            vf_q       <= alu_overflow;
                            state_q    <= S_FETCH;
                        end
                        c_OP_LDI, c_OP_JZ: begin
                            state_q <= S_OPND;
                        end
                        c_OP_OUT: begin
                            out_data_q  <= rf_q[w_rd];
                            out_valid_q <= 1'b1;
                            state_q     <= S_OUT_WAIT;
                        end
                        c_OP_NOP: begin
                            state_q <= S_FETCH;
                        end
                        default: begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                    endcase
                end
                S_OPND: begin
                    if (w_op == c_OP_LDI) begin
                        rf_q[w_rd] <= imem_data;
                        pc_q       <= pc_q + 1'b1;
                    end else if (zf_q) begin
                        pc_q <= imem_data;
                    end else begin
                        pc_q <= pc_q + 1'b1;
                    end
                    state_q <= S_FETCH;
                end
                S_OUT_WAIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_control_unit
// Brief   : Instruction-level reference model plus directed and random programs.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cpu_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] imem_addr, imem_data = 8'h00;
    logic       imem_en;
    logic [2:0] alu_opcode;
    logic [7:0] alu_a, alu_b, alu_res;
    logic       alu_zero, alu_overflow;
    logic [7:0] out_data;
    logic       out_valid, out_ready;
    logic       zf, vf, halted;
    logic [7:0] pc;

    logic       rdy_random = 1'b0;
    logic       rdy_dir = 1'b1;
    logic       rnd_rdy = 1'b0;
    assign out_ready = rdy_random ? rnd_rdy : rdy_dir;

    logic [7:0] mem [256];
    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] beats_d[$];
    logic       beats_z[$];
    logic       beats_v[$];
    logic [7:0] fetch_q[$];

    cpu_control_unit #(.WIDTH(8), .NREGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .zf(zf), .vf(vf), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_data <= mem[imem_addr];
        #1 rnd_rdy = ($urandom_range(0, 2) != 0);
    end

    task automatic alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            output logic [7:0] r, output logic z, output logic v);
        v = 1'b0;
        case (op)
            3'd0: begin
                r = a + b;
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd1:    r = a & b;
            3'd2:    r = ~a;
            default: r = 8'h00;
        endcase
        z = (r == 8'h00);
    endtask

    always_comb begin
        alu_res = 8'h00; alu_zero = 1'b0; alu_overflow = 1'b0;
        alu_calc(alu_opcode, alu_a, alu_b, alu_res, alu_zero, alu_overflow);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: each instruction is a fixed cycle schedule
    // (fetch, decode, execute, then operand fetch / output wait / halt).
    logic       m_valid = 1'b0;
    logic [7:0] m_ip, m_od, m_r [4];
    logic       m_zf, m_vf;
    int         m_k;

    always @(negedge clk) begin
        logic [7:0] ins, nxt, res;
        logic [2:0] op;
        logic [1:0] rd, rs;
        logic       en_x, alu_x, z, v;
        if (m_valid) begin
            ins   = mem[m_ip];
            op    = ins[7:5];
            rd    = ins[4:3];
            rs    = ins[2:1];
            nxt   = m_ip + 8'd1;
            en_x  = (m_k == 0) || (m_k == 2 && (op == 3'd3 || op == 3'd4));
            alu_x = (m_k == 2) && (op <= 3'd2);
            chk("pc", pc, (m_k < 2) ? m_ip : nxt);
            chk("imem_en", imem_en, en_x);
            if (en_x) chk("imem_addr", imem_addr, (m_k == 0) ? m_ip : nxt);
            chk("alu_opcode", alu_opcode, alu_x ? op : 3'd0);
            chk("alu_a", alu_a, alu_x ? m_r[rd] : 8'h00);
            chk("alu_b", alu_b, alu_x ? m_r[rs] : 8'h00);
            chk("out_valid", out_valid, (m_k == 3) && (op == 3'd5));
            chk("out_data", out_data, m_od);
            chk("halted", halted, (m_k == 3) && (op == 3'd7));
            chk("zf", zf, m_zf);
            chk("vf", vf, m_vf);
            if (out_valid && out_ready) begin
                beats_d.push_back(out_data);
                beats_z.push_back(zf);
                beats_v.push_back(vf);
            end
            if (imem_en) fetch_q.push_back(imem_addr);
        end
        if (!rst_n) begin
            m_valid = 1'b1; m_ip = 8'h00; m_od = 8'h00; m_zf = 1'b0; m_vf = 1'b0; m_k = 0;
            for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        end else if (m_valid) begin
            if (m_k < 2) begin
                m_k++;
            end else if (m_k == 2) begin
                if (op <= 3'd2) begin
                    alu_calc(op, m_r[rd], m_r[rs], res, z, v);
                    m_r[rd] = res; m_zf = z; m_vf = v;
                    m_ip = nxt; m_k = 0;
                end else if (op == 3'd6) begin
                    m_ip = nxt; m_k = 0;
                end else begin
                    if (op == 3'd5) m_od = m_r[rd];
                    m_k = 3;
                end
            end else begin
                if (op == 3'd3) begin
                    m_r[rd] = mem[nxt]; m_ip = m_ip + 8'd2; m_k = 0;
                end else if (op == 3'd4) begin
                    m_ip = m_zf ? mem[nxt] : m_ip + 8'd2; m_k = 0;
                end else if (op == 3'd5 && out_ready) begin
                    m_ip = nxt; m_k = 0;
                end
            end
        end
    end

    task automatic reset_begin();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
    endtask

    task automatic reset_end();
        @(posedge clk); #1 rst_n = 1'b1;
        beats_d.delete(); beats_z.delete(); beats_v.delete(); fetch_q.delete();
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk); n++;
        end
        chk("halt_reached", halted, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: LDI/LDI/ADD/OUT/HALT with sink always ready.
        reset_begin();
        mem[0] = 8'h60; mem[1] = 8'h05; mem[2] = 8'h68; mem[3] = 8'h03;
        mem[4] = 8'h02; mem[5] = 8'hA0; mem[6] = 8'hE0;
        rdy_dir = 1'b1;
        reset_end();
        @(negedge clk);
        chk("reset_pc", pc, 8'h00);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 8'h00);
        chk("reset_halted", halted, 1'b0);
        chk("reset_flags", {zf, vf}, 2'b00);
        wait_halt(100);
        chk("t1_beats", beats_d.size(), 1);
        chk("t1_data", beats_d[0], 8'h08);
        chk("t1_flags", {zf, vf}, 2'b00);
        chk("t1_pc", pc, 8'h07);

        // Test 2: signed overflow then AND to zero.
        reset_begin();
        mem[0] = 8'h60; mem[1] = 8'h7F; mem[2] = 8'h68; mem[3] = 8'h01;
        mem[4] = 8'h02; mem[5] = 8'hA0; mem[6] = 8'h24; mem[7] = 8'hA0;
        reset_end();
        wait_halt(100);
        chk("t2_beats", beats_d.size(), 2);
        chk("t2_add_data", beats_d[0], 8'h80);
        chk("t2_add_flags", {beats_z[0], beats_v[0]}, 2'b01);
        chk("t2_and_data", beats_d[1], 8'h00);
        chk("t2_and_flags", {beats_z[1], beats_v[1]}, 2'b10);

        // Test 3a: JZ taken.
        reset_begin();
        mem[0] = 8'h24; mem[1] = 8'h80; mem[2] = 8'h20;
        mem[8'h20] = 8'h78; mem[8'h21] = 8'h5A; mem[8'h22] = 8'hB8;
        reset_end();
        wait_halt(100);
        chk("t3a_jump_fetch", fetch_q[3], 8'h20);
        chk("t3a_data", beats_d[0], 8'h5A);
        chk("t3a_pc", pc, 8'h24);

        // Test 3b: JZ at 0x10 not taken.
        reset_begin();
        mem[0] = 8'h60; mem[1] = 8'h01; mem[2] = 8'h00;
        for (int i = 3; i < 16; i++) mem[i] = 8'hC0;
        mem[8'h10] = 8'h80; mem[8'h11] = 8'h20; mem[8'h12] = 8'hA0;
        reset_end();
        wait_halt(200);
        chk("t3b_fallthrough", fetch_q[fetch_q.size() - 2], 8'h12);
        chk("t3b_data", beats_d[0], 8'h02);
        chk("t3b_pc", pc, 8'h14);

        // Test 4: output backpressure.
        reset_begin();
        mem[0] = 8'h68; mem[1] = 8'hA5; mem[2] = 8'hA8;
        rdy_dir = 1'b0;
        reset_end();
        for (int n = 0; n < 30 && !out_valid; n++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", out_valid, 1'b1);
            chk("t4_hold_data", out_data, 8'hA5);
            chk("t4_no_fetch", imem_en, 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1 rdy_dir = 1'b1;
        @(negedge clk);
        chk("t4_xfer_valid", out_valid, 1'b1);
        @(negedge clk);
        chk("t4_after_valid", out_valid, 1'b0);
        chk("t4_fetch_en", imem_en, 1'b1);
        chk("t4_fetch_addr", imem_addr, 8'h03);
        chk("t4_beats", beats_d.size(), 1);

        // Test 5: NOP at 0xFF wraps the PC.
        reset_begin();
        mem[0] = 8'h24; mem[1] = 8'h80; mem[2] = 8'hFF; mem[8'hFF] = 8'hC0;
        reset_end();
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (imem_en && imem_addr == 8'hFF) break;
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (imem_en) break;
        end
        chk("t5_wrap_en", imem_en, 1'b1);
        chk("t5_wrap_addr", imem_addr, 8'h00);
        chk("t5_wrap_pc", pc, 8'h00);

        // Test 6: reset during the operand cycle of an LDI.
        reset_begin();
        mem[0] = 8'h60; mem[1] = 8'h33; mem[2] = 8'hA0;
        reset_end();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (imem_en && imem_addr == 8'h01) break;
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        mem[0] = 8'hA0; mem[1] = 8'hE0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_pc", pc, 8'h00);
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_fetch", {imem_en, imem_addr}, 9'h100);
        wait_halt(50);
        chk("t6_beats", beats_d.size(), 1);
        chk("t6_reg_zero", beats_d[0], 8'h00);
        chk("t6_pc_end", pc, 8'h02);

        // Random programs with random backpressure and sporadic resets.
        for (int run = 0; run < 8; run++) begin
            reset_begin();
            for (int i = 0; i < 256; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (b[7:5] == 3'd7 && $urandom_range(0, 7) != 0) b = 8'hC0;
                mem[i] = b;
            end
            rdy_random = 1'b1;
            reset_end();
            for (int c = 0; c < 300; c++) begin
                @(posedge clk); #1 rst_n = ($urandom_range(0, 149) != 0);
            end
            rdy_random = 1'b0;
        end

        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
